// File: rtl/zion_arb_pkg.sv
// Shared types and helpers for the zion round-robin grant arbiter.
// Holds the arbiter state encoding and a one-hot to binary index converter.
package zion_arb_pkg;

   // Widest request bitmap the index helper supports.
   localparam int MAX_REQ = 64;
   localparam int MAX_IDX_W = 6;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   // OR-reduces the indices of set bits; exact for one-hot or zero inputs.
   function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) idx = idx | MAX_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/zion_lsb_onehot_pick.sv
// Combinational lowest-set-bit picker: returns a one-hot vector of the
// least significant set bit of req, or zero when req is zero.
module zion_lsb_onehot_pick #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] req,
   output logic [WIDTH-1:0] onehot
);

   // Two's complement isolates the lowest set bit without a priority chain.
   assign onehot = req & (~req + WIDTH'(1));

endmodule

// File: rtl/zion_rr_grant_arbiter.sv
// Registered round-robin arbiter: grants one requester at a time, holds the
// grant until release, withdrawal or optional timeout, then rotates priority.
module zion_rr_grant_arbiter
   import zion_arb_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int MAX_HOLD = 0,
   parameter int IDX_W    = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] iReq,
   input  logic               iRelease,
   output logic [NUM_REQ-1:0] oGnt,
   output logic [IDX_W-1:0]   oGntIdx,
   output logic               oGntVld,
   output logic               oExpire
);

   localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

   if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || MAX_HOLD < 0) begin : g_param_err
`ifdef CHECK_ERR_EXIT
      $fatal(1, "zion_rr_grant_arbiter: illegal NUM_REQ=%0d or MAX_HOLD=%0d", NUM_REQ, MAX_HOLD);
`else
      $error("zion_rr_grant_arbiter: illegal NUM_REQ=%0d or MAX_HOLD=%0d", NUM_REQ, MAX_HOLD);
`endif
   end

   arb_state_e         state;
   arb_state_e         state_next;
   logic [IDX_W-1:0]   ptr;
   logic [CNT_W-1:0]   hold_cnt;

   logic [NUM_REQ-1:0] hi_mask;
   logic [NUM_REQ-1:0] req_masked;
   logic [NUM_REQ-1:0] pick_masked;
   logic [NUM_REQ-1:0] pick_raw;
   logic [NUM_REQ-1:0] pick;
   logic [IDX_W-1:0]   pick_idx;

   logic any_req;
   logic winner_req;
   logic timeout_hit;
   logic grant_exit;
   logic load_grant;
   logic clear_grant;
   logic cnt_inc;
   logic expire_next;

   // Requesters strictly above the last winner get first pick.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         hi_mask[i] = (IDX_W'(i) > ptr);
      end
   end

   assign req_masked = iReq & hi_mask;

   zion_lsb_onehot_pick #(.WIDTH(NUM_REQ)) u_pick_masked (
      .req    (req_masked),
      .onehot (pick_masked)
   );

   zion_lsb_onehot_pick #(.WIDTH(NUM_REQ)) u_pick_raw (
      .req    (iReq),
      .onehot (pick_raw)
   );

   assign pick     = (|req_masked) ? pick_masked : pick_raw;
   assign pick_idx = IDX_W'(onehot2idx(MAX_REQ'(pick)));

   assign any_req     = |iReq;
   assign winner_req  = |(iReq & oGnt);
   assign timeout_hit = (MAX_HOLD > 0) && (hold_cnt == CNT_W'(MAX_HOLD - 1));
   assign grant_exit  = iRelease | ~winner_req | timeout_hit;

   // NOTE: asynchronous reset lists rst_n in the sensitivity list and every
   // sequential block uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: each always_comb assigns every output a default first so no latch
   // is inferred on paths the case statement leaves untouched.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (any_req) state_next = BUSY;
         BUSY:    if (grant_exit && !any_req) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      load_grant  = 1'b0;
      clear_grant = 1'b0;
      cnt_inc     = 1'b0;
      expire_next = 1'b0;
      unique case (state)
         IDLE: load_grant = any_req;
         BUSY: begin
            if (grant_exit) begin
               load_grant  = any_req;
               clear_grant = ~any_req;
               // A timeout that coincides with a release or withdrawal is a normal exit.
               expire_next = timeout_hit & ~iRelease & winner_req;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: clear_grant = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oGnt     <= '0;
         oGntIdx  <= '0;
         oGntVld  <= 1'b0;
         oExpire  <= 1'b0;
         ptr      <= IDX_W'(NUM_REQ - 1);
         hold_cnt <= '0;
      end else begin
         oExpire <= expire_next;
         if (load_grant) begin
            oGnt     <= pick;
            oGntIdx  <= pick_idx;
            oGntVld  <= 1'b1;
            ptr      <= pick_idx;
            hold_cnt <= '0;
         end else if (clear_grant) begin
            oGnt    <= '0;
            oGntIdx <= '0;
            oGntVld <= 1'b0;
         end else if (cnt_inc) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
         end
      end
   end

endmodule
